clfsr_decrypt: RTL and testbench
================================

# clfsr_decrypt

Receiver-side counterpart of the chaotic-LFSR image encryptor. It consumes a stream of encrypted RGB pixels and, per pixel, one key triplet from the LFSR/chaotic key generator, and emits the recovered plaintext pixels. It undoes the encryptor's XOR-with-cipher-chaining diffusion and signals completion once a full frame has been recovered. It sits between the ciphertext source and the image sink, sharing the key generator's `Key_ready`/`R_random`/`G_random`/`B_random` interface.

## Interface
- `NUM_PIXELS`, 65536: pixels per frame (256×256 default); must be ≥ 1.
- `IV`, 8'hA5: chaining seed used as the "previous ciphertext" for pixel 0 on every channel.
- `CW`, `$clog2(NUM_PIXELS+1)`: pixel-counter width (derived, do not override).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a frame (honoured only in IDLE).
- `Key_ready` in 1: key triplet valid.
- `R_random`, `G_random`, `B_random` in 8 each: key triplet.
- `key_ack` out 1: key triplet consumed this cycle.
- `in_valid` in 1: ciphertext pixel valid.
- `in_ready` out 1: decryptor accepts ciphertext this cycle.
- `in_R`, `in_G`, `in_B` in 8 each: ciphertext pixel.
- `out_valid` out 1: plaintext pixel valid.
- `out_ready` in 1: sink accepts plaintext.
- `out_R`, `out_G`, `out_B` out 8 each: plaintext pixel.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `pix_cnt` out CW: pixels accepted in the current or most recent frame.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`. On that edge: chain registers `cR`/`cG`/`cB` ← `IV`; `pix_cnt` ← 0.
  - RUN → DRAIN on the edge that accepts pixel number `NUM_PIXELS` (i.e. `pix_cnt` becomes `NUM_PIXELS`).
  - DRAIN → IDLE once the output slot is empty: `!out_valid`, or `out_valid && out_ready`. `done` = 1 for exactly that cycle (registered pulse, asserted the cycle after the condition holds).
- `in_ready` = (state == RUN) && `Key_ready` && (`!out_valid` || `out_ready`). Combinational.
- `fire` = `in_valid` && `in_ready`. `key_ack` = `fire`. Key and ciphertext are always consumed together.
- On `fire`, per channel X ∈ {R,G,B}:
  - `out_X` ← `in_X` ^ `X_random` ^ `cX`.
  - `cX` ← `in_X`.
  - `out_valid` ← 1.
  - `pix_cnt` ← `pix_cnt` + 1.
- All arithmetic is 8-bit XOR; there is no carry or width growth.
- `out_valid` clears on `out_ready` when there is no simultaneous `fire`. A simultaneous drain and fire keeps `out_valid` at 1 and loads the new pixel (full throughput).
- `start` while `busy` is ignored. `start` in the same cycle as `done` is also ignored; the FSM is still in DRAIN.
- `pix_cnt` holds its final value in IDLE until the next `start`.

## Timing
- Latency: 1 cycle from `fire` to `out_valid`. Throughput: 1 pixel/cycle when `Key_ready`, `in_valid` and `out_ready` are all high.
- Reset values: `out_valid`=0, `out_R/G/B`=0, `done`=0, `busy`=0, `pix_cnt`=0, `cR/cG/cB`=`IV`, FSM = IDLE. `in_ready`=0 and `key_ack`=0 (derived).
- Reset mid-frame aborts immediately. A pending output pixel is discarded and `done` is not produced.
- `Key_ready` low stalls input; `key_ack` never asserts while `Key_ready`=0.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `in_ready`=0, and outputs and chain registers hold stable.
- `NUM_PIXELS`=1: RUN lasts until the first `fire`, then the FSM enters DRAIN.

## Configuration
- `CLFSR_DECRYPT_CHAIN_EN` defined: chained decryption as above, `out_X` = `in_X` ^ key ^ `cX`.
- Undefined: plain stream XOR, `out_X` = `in_X` ^ key. The chain registers and `IV` are not implemented; `IV` is ignored. All handshakes and timing are unchanged.

## Test plan
- Reset/idle: hold `rst`=0, then release; drive `in_valid`=1, `Key_ready`=1 with no `start` → `in_ready`=0, `key_ack`=0, `out_valid`=0, `busy`=0 indefinitely.
- Chained decode (CHAIN_EN, IV=A5): `start`, then pixel 0 C=(12,34,56), K=(FF,00,0F) → out (48,91,FC) one cycle later. Pixel 1 C=(00,00,00), K=(00,00,00) → out (12,34,56).
- Plain decode (CHAIN_EN undefined): same pixel 0 → out (ED,34,59).
- Backpressure/key stall, `NUM_PIXELS`=4:
  - hold `out_ready`=0 for 3 cycles → outputs stable, `in_ready`=0.
  - drop `Key_ready` for 2 cycles → `key_ack`=0.
  - frame still yields exactly 4 outputs in order.
- Frame end, `NUM_PIXELS`=4, continuous flow: `done` pulses once, 1 cycle after the 4th output handshake; `pix_cnt`=4; `start` in the `done` cycle is ignored.
- Reset mid-frame after 2 pixels: `rst` low → `out_valid`=0, `pix_cnt`=0, no `done`. A new `start` restarts chaining from `IV` (pixel 0 reproduces (48,91,FC)).

Source files
------------

// File: rtl/clfsr_decrypt.sv
// Chaotic-LFSR image decryptor: undoes per-pixel key XOR and ciphertext chaining, flags frame end.
// Define CLFSR_DECRYPT_CHAIN_EN for chained decryption; otherwise a plain key-stream XOR is used.
module clfsr_decrypt #(
    parameter int          NUM_PIXELS = 65536,
    parameter logic [7:0]  IV         = 8'hA5,
    localparam int         CW         = $clog2(NUM_PIXELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          Key_ready,
    input  logic [7:0]    R_random,
    input  logic [7:0]    G_random,
    input  logic [7:0]    B_random,
    output logic          key_ack,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_R,
    input  logic [7:0]    in_G,
    input  logic [7:0]    in_B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_R,
    output logic [7:0]    out_G,
    output logic [7:0]    out_B,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pix_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [2:0][7:0] out_q, out_d;
    logic [2:0][7:0] in_ch, key_ch, plain_ch;
    logic            slot_free, fire, last_pix, unused_iv;

    assign in_ch     = {in_R, in_G, in_B};
    assign key_ch    = {R_random, G_random, B_random};
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == RUN) && Key_ready && slot_free;
    assign fire      = in_valid && in_ready;
    assign key_ack   = fire;
    assign last_pix  = (pix_cnt_q == CW'(NUM_PIXELS - 1));
    assign unused_iv = ^IV;

    // One lane per colour channel; each lane owns its own chaining register.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
`ifdef CLFSR_DECRYPT_CHAIN_EN
        logic [7:0] c_q, c_d;

        always_comb begin
            c_d = c_q;
            if (state_q == IDLE && start) begin
                c_d = IV;
            end else if (fire) begin
                c_d = in_ch[gi];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                c_q <= IV;
            end else begin
                c_q <= c_d;
            end
        end

        assign plain_ch[gi] = in_ch[gi] ^ key_ch[gi] ^ c_q;
`else
        assign plain_ch[gi] = in_ch[gi] ^ key_ch[gi];
`endif
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        pix_cnt_d   = pix_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    pix_cnt_d = '0;
                end
            end
            RUN: begin
                if (fire && last_pix) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stay in DRAIN while done is high so a start in that cycle is ignored.
                if (done_q) begin
                    state_d = IDLE;
                end else if (slot_free) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            out_valid_d = 1'b1;
            out_d       = plain_ch;
            pix_cnt_d   = pix_cnt_q + CW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            pix_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            pix_cnt_q   <= pix_cnt_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_R     = out_q[2];
    assign out_G     = out_q[1];
    assign out_B     = out_q[0];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_clfsr_decrypt.sv
// Bench for clfsr_decrypt: table-driven pixel vectors checked through a scoreboard queue,
// plus hand-written backpressure, key-stall, frame-end and mid-frame reset sequences.
module tb_clfsr_decrypt;
    localparam int NP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       Key_ready = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] R_random = '0, G_random = '0, B_random = '0;
    logic [7:0] in_R = '0, in_G = '0, in_B = '0;
    logic       key_ack, in_ready, out_valid, busy, done;
    logic [7:0] out_R, out_G, out_B;
    logic [2:0] pix_cnt;

    typedef struct {
        logic [23:0] c;
        logic [23:0] k;
        logic [23:0] e;
    } vec_t;

    vec_t        tbl [NP];
    logic [23:0] cur_exp = '0;
    logic [23:0] sb_q [$];
    int          total = 0, bad = 0;
    int          cyc = 0, n_out = 0, n_done = 0, hs_cyc = -1, done_cyc = -1;
    bit          got;

    clfsr_decrypt #(.NUM_PIXELS(NP), .IV(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Key_ready(Key_ready), .R_random(R_random), .G_random(G_random), .B_random(B_random),
        .key_ack(key_ack), .in_valid(in_valid), .in_ready(in_ready),
        .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_G(out_G), .out_B(out_B),
        .busy(busy), .done(done), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                hs_cyc = cyc;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL pixel_unexpected: got %h expected none", {out_R, out_G, out_B});
                end else begin
                    logic [23:0] e;
                    e = sb_q.pop_front();
                    $display("out pixel: got %h expected %h", {out_R, out_G, out_B}, e);
                    if ({out_R, out_G, out_B} !== e) begin
                        bad++;
                        $display("FAIL pixel: got %h expected %h", {out_R, out_G, out_B}, e);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int i);
        {in_R, in_G, in_B}             = tbl[i].c;
        {R_random, G_random, B_random} = tbl[i].k;
        cur_exp                        = tbl[i].e;
        in_valid                       = 1'b1;
    endtask

    task automatic send_px(input int i);
        int n;
        set_px(i);
        Key_ready = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no accept expected accept of pixel %0d", i);
                break;
            end
        end
        tick();
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done pulse");
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
`ifdef CLFSR_DECRYPT_CHAIN_EN
        tbl[0] = '{c: 24'h123456, k: 24'hFF000F, e: 24'h4891FC};
        tbl[1] = '{c: 24'h000000, k: 24'h000000, e: 24'h123456};
        tbl[2] = '{c: 24'hABCDEF, k: 24'h112233, e: 24'hBAEFDC};
        tbl[3] = '{c: 24'h010203, k: 24'h102030, e: 24'hBAEFDC};
`else
        tbl[0] = '{c: 24'h123456, k: 24'hFF000F, e: 24'hED3459};
        tbl[1] = '{c: 24'h000000, k: 24'h000000, e: 24'h000000};
        tbl[2] = '{c: 24'hABCDEF, k: 24'h112233, e: 24'hBAEFDC};
        tbl[3] = '{c: 24'h010203, k: 24'h102030, e: 24'h112233};
`endif
        // Reset and idle behaviour with inputs asserted but no start
        in_valid = 1'b1; Key_ready = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_out_rgb", {out_R, out_G, out_B}, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_in_ready", in_ready, 0);
            chk("idle_key_ack", key_ack, 0);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end
        in_valid = 1'b0;

        // Frame A: continuous flow, start during done is ignored
        do_start();
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < NP; i++) send_px(i);
        in_valid = 1'b0;
        wait_done(got);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_latency", done_cyc, hs_cyc + 1);
        chk("start_in_done_ignored", busy, 0);
        tick();
        tick();
        chk("idle_after_frame", busy, 0);
        chk("frameA_pix_cnt", pix_cnt, NP);
        chk("frameA_done_count", n_done, 1);
        chk("frameA_out_count", n_out, NP);

        // Frame B: output backpressure and key stall
        n_out = 0; n_done = 0;
        out_ready = 1'b0;
        do_start();
        send_px(0);
        set_px(1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_key_ack", key_ack, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_hold", {out_R, out_G, out_B}, tbl[0].e);
            tick();
        end
        out_ready = 1'b1;
        send_px(1);
        set_px(2);
        Key_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("kstall_key_ack", key_ack, 0);
            chk("kstall_in_ready", in_ready, 0);
            tick();
        end
        send_px(2);
        send_px(3);
        in_valid = 1'b0;
        wait_done(got);
        tick();
        chk("frameB_out_count", n_out, NP);
        chk("frameB_done_count", n_done, 1);
        chk("frameB_pix_cnt", pix_cnt, NP);

        // Frame C: reset after two pixels, then restart from IV
        n_done = 0;
        do_start();
        send_px(0);
        send_px(1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pix_cnt", pix_cnt, 0);
        chk("midrst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_no_done", n_done, 0);
        n_out = 0;
        do_start();
        for (int i = 0; i < NP; i++) send_px(i);
        in_valid = 1'b0;
        wait_done(got);
        tick();
        chk("frameC_out_count", n_out, NP);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
